fetch_unit: RTL and testbench

- Instruction-fetch stage that produces the 32-bit instruction word and PC consumed by the decode stage's controller.
- Owns the fetch PC and an instruction-memory request/acknowledge handshake.
- Holds the IF/ID pipeline register and a one-entry hold buffer, so stalls never drop a returned instruction.
- Accepts branch/jump redirects from EX and stall/flush controls from the hazard unit.

---
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, the imem req/ack handshake,
// the IF/ID register and a one-entry hold buffer so a stalled return is never lost.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        stall_d,
    input  logic        flush_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);

    typedef enum logic [1:0] {FETCH, DROP, HOLD} state_t;

    state_t      state, state_nx;
    logic [31:0] pc_f, pc_f_nx;
    logic [31:0] redir_pc, redir_pc_nx;
    logic [31:0] buf_instr, buf_instr_nx;
    logic [31:0] buf_pc, buf_pc_nx;
    logic        load;
    logic [31:0] load_instr, load_pc;

    assign imem_req  = ((state == FETCH) || (state == DROP)) && !rst;
    assign imem_addr = pc_f;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            pc_f      <= RESET_PC;
            redir_pc  <= RESET_PC;
            buf_instr <= NOP_INSTR;
            buf_pc    <= RESET_PC;
        end else begin
            state     <= state_nx;
            pc_f      <= pc_f_nx;
            redir_pc  <= redir_pc_nx;
            buf_instr <= buf_instr_nx;
            buf_pc    <= buf_pc_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        pc_f_nx      = pc_f;
        redir_pc_nx  = redir_pc;
        buf_instr_nx = buf_instr;
        buf_pc_nx    = buf_pc;
        load         = 1'b0;
        load_instr   = buf_instr;
        load_pc      = buf_pc;
        case (state)
            FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_f_nx = redirect_target;
                    end else if (!stall_d && !flush_d) begin
                        load       = 1'b1;
                        load_instr = imem_rdata;
                        load_pc    = pc_f;
                        pc_f_nx    = pc_f + 32'd4;
                    end else begin
                        buf_instr_nx = imem_rdata;
                        buf_pc_nx    = pc_f;
                        pc_f_nx      = pc_f + 32'd4;
                        state_nx     = HOLD;
                    end
                end else if (redirect) begin
                    // Address must stay put until the outstanding ack; park the target.
                    redir_pc_nx = redirect_target;
                    state_nx    = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    pc_f_nx  = redirect ? redirect_target : redir_pc;
                    state_nx = FETCH;
                end else if (redirect) begin
                    redir_pc_nx = redirect_target;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_f_nx  = redirect_target;
                    state_nx = FETCH;
                end else if (!stall_d && !flush_d) begin
                    load     = 1'b1;
                    state_nx = FETCH;
                end
            end
            default: state_nx = FETCH;
        endcase
    end

    // IF/ID register: flush beats stall beats load; otherwise a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= 32'h0;
            pc_plus4_d <= 32'h0;
            valid_d    <= 1'b0;
        end else if (flush_d) begin
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
        end else if (stall_d) begin
            instr_d <= instr_d;
        end else if (load) begin
            instr_d    <= load_instr;
            pc_d       <= load_pc;
            pc_plus4_d <= load_pc + 32'd4;
            valid_d    <= 1'b1;
        end else begin
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle tables for redirect/stall/flush corners plus a
// scoreboard run against a wait-stated memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        stall_d = 1'b0;
    logic        flush_d = 1'b0;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
    logic        valid_d;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Memory returns addr|1 so every word identifies the address it came from.
    assign imem_rdata = imem_ack ? (imem_addr | 32'h1) : 32'hDEAD_BEEF;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_target(redirect_target),
        .stall_d(stall_d), .flush_d(flush_d),
        .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
    );

    typedef struct {
        logic        rst, ack, redir;
        logic [31:0] tgt;
        logic        stall, flush;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] einstr, epc;
    } vec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];

    function automatic vec_t v(input logic r, a, rd, input logic [31:0] t,
                               input logic s, f, eq, input logic [31:0] ea,
                               input logic ev, input logic [31:0] ei, ep);
        vec_t x;
        x.rst = r; x.ack = a; x.redir = rd; x.tgt = t; x.stall = s; x.flush = f;
        x.ereq = eq; x.eaddr = ea; x.evalid = ev; x.einstr = ei; x.epc = ep;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_row(input int idx);
        vec_t r;
        r = tbl[idx];
        @(posedge clk);
        #1;
        rst = r.rst; imem_ack = r.ack; redirect = r.redir; redirect_target = r.tgt;
        stall_d = r.stall; flush_d = r.flush;
        #4;
        chk($sformatf("row%0d req", idx), {31'b0, imem_req}, {31'b0, r.ereq});
        chk($sformatf("row%0d addr", idx), imem_addr, r.eaddr);
        chk($sformatf("row%0d valid", idx), {31'b0, valid_d}, {31'b0, r.evalid});
        chk($sformatf("row%0d instr", idx), instr_d, r.einstr);
        if (r.evalid) begin
            chk($sformatf("row%0d pc", idx), pc_d, r.epc);
            chk($sformatf("row%0d pc4", idx), pc_plus4_d, r.epc + 32'd4);
        end
    endtask

    logic [31:0] exp_addr;

    task automatic sb_sample(input int k);
        sb_t e;
        if (valid_d) begin
            if (sbq.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL sb_extra cyc%0d: got valid pc %h, expected no instruction", k, pc_d);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("sb_instr cyc%0d", k), instr_d, e.instr);
                chk($sformatf("sb_pc cyc%0d", k), pc_d, e.pc);
                chk($sformatf("sb_pc4 cyc%0d", k), pc_plus4_d, e.pc + 32'd4);
            end
        end
        if (imem_req) chk($sformatf("sb_addr cyc%0d", k), imem_addr, exp_addr);
        if (imem_req && imem_ack) begin
            sbq.push_back('{instr: exp_addr | 32'h1, pc: exp_addr});
            exp_addr = exp_addr + 32'd4;
        end
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;
    int split;

    initial begin
        // r  a  rd tgt           s  f  req addr          v  instr         pc
        tbl.push_back(v(1, 0, 0, 0,            0, 0, 0, 32'h0,        0, NOP,          0));
        tbl.push_back(v(1, 0, 0, 0,            0, 0, 0, 32'h0,        0, NOP,          0));
        tbl.push_back(v(0, 1, 0, 0,            0, 0, 1, 32'h0,        0, NOP,          0));
        tbl.push_back(v(0, 1, 0, 0,            0, 0, 1, 32'h4,        1, 32'h1,        32'h0));
        tbl.push_back(v(0, 1, 0, 0,            0, 0, 1, 32'h8,        1, 32'h5,        32'h4));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 1, 32'hC,        1, 32'h9,        32'h8));
        tbl.push_back(v(0, 1, 0, 0,            0, 0, 1, 32'hC,        0, NOP,          0));
        tbl.push_back(v(0, 1, 0, 0,            1, 0, 1, 32'h10,       1, 32'hD,        32'hC));
        tbl.push_back(v(0, 0, 0, 0,            1, 0, 0, 32'h14,       1, 32'hD,        32'hC));
        tbl.push_back(v(0, 0, 0, 0,            1, 0, 0, 32'h14,       1, 32'hD,        32'hC));
        tbl.push_back(v(0, 0, 0, 0,            1, 0, 0, 32'h14,       1, 32'hD,        32'hC));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 0, 32'h14,       1, 32'hD,        32'hC));
        tbl.push_back(v(0, 1, 0, 0,            0, 0, 1, 32'h14,       1, 32'h11,       32'h10));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 1, 32'h18,       1, 32'h15,       32'h14));
        tbl.push_back(v(0, 1, 0, 0,            0, 0, 1, 32'h18,       0, NOP,          0));
        tbl.push_back(v(0, 1, 0, 0,            0, 0, 1, 32'h1C,       1, 32'h19,       32'h18));
        tbl.push_back(v(0, 0, 1, 32'h100,      0, 0, 1, 32'h20,       1, 32'h1D,       32'h1C));
        tbl.push_back(v(0, 0, 1, 32'h200,      0, 0, 1, 32'h20,       0, NOP,          0));
        tbl.push_back(v(0, 1, 0, 0,            0, 0, 1, 32'h20,       0, NOP,          0));
        tbl.push_back(v(0, 1, 0, 0,            0, 0, 1, 32'h200,      0, NOP,          0));
        tbl.push_back(v(0, 0, 0, 0,            1, 1, 1, 32'h204,      1, 32'h201,      32'h200));
        tbl.push_back(v(0, 1, 1, 32'hFFFF_FFFC,0, 0, 1, 32'h204,      0, NOP,          0));
        tbl.push_back(v(0, 1, 0, 0,            0, 0, 1, 32'hFFFF_FFFC,0, NOP,          0));
        tbl.push_back(v(0, 1, 0, 0,            0, 0, 1, 32'h0,        1, 32'hFFFF_FFFD,32'hFFFF_FFFC));
        split = tbl.size();
        // After async reset: stall on ack into HOLD, redirect out of HOLD,
        // redirect during DROP's ack cycle, flush on ack then release.
        tbl.push_back(v(1, 0, 0, 0,            0, 0, 0, 32'h0,        0, NOP,          0));
        tbl.push_back(v(0, 1, 0, 0,            1, 0, 1, 32'h0,        0, NOP,          0));
        tbl.push_back(v(0, 0, 1, 32'h40,       0, 0, 0, 32'h4,        0, NOP,          0));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 1, 32'h40,       0, NOP,          0));
        tbl.push_back(v(0, 0, 1, 32'h80,       0, 0, 1, 32'h40,       0, NOP,          0));
        tbl.push_back(v(0, 1, 1, 32'hC0,       0, 0, 1, 32'h40,       0, NOP,          0));
        tbl.push_back(v(0, 1, 0, 0,            0, 0, 1, 32'hC0,       0, NOP,          0));
        tbl.push_back(v(0, 1, 0, 0,            0, 1, 1, 32'hC4,       1, 32'hC1,       32'hC0));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 0, 32'hC8,       0, NOP,          0));
        tbl.push_back(v(0, 1, 0, 0,            0, 0, 1, 32'hC8,       1, 32'hC5,       32'hC4));
        tbl.push_back(v(0, 0, 0, 0,            0, 0, 1, 32'hCC,       1, 32'hC9,       32'hC8));

        for (int i = 0; i < split; i++) apply_row(i);

        // Async reset mid-cycle: outputs must change with no clock edge.
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        #2;
        chk("pre_rst valid", {31'b0, valid_d}, 32'h1);
        chk("pre_rst addr", imem_addr, 32'h4);
        rst = 1'b1;
        #1;
        chk("async_rst req", {31'b0, imem_req}, 32'h0);
        chk("async_rst addr", imem_addr, 32'h0);
        chk("async_rst valid", {31'b0, valid_d}, 32'h0);
        chk("async_rst instr", instr_d, NOP);
        chk("async_rst pc", pc_d, 32'h0);
        chk("async_rst pc4", pc_plus4_d, 32'h0);

        for (int i = split; i < tbl.size(); i++) apply_row(i);

        // Wait-stated memory: ack every third cycle, scoreboard the stream.
        @(posedge clk);
        #1;
        rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        sbq.delete();
        exp_addr = 32'h0;
        for (int k = 0; k < 39; k++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            imem_ack = (k < 36) && (k % 3 == 2);
            #4;
            sb_sample(k);
        end
        chk("sb_drained", sbq.size(), 32'd0);
        chk("sb_final_addr", imem_addr, 32'd48);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
